// File: rtl/hram_frame_writer_pkg.sv
// Shared types and the buffer-selection helper for the HyperRAM triple-buffer frame writer.
package hram_fw_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      WRITE   = 2'd2,
      DISCARD = 2'd3
   } state_t;

   localparam int         NUM_BUF  = 3;
   localparam logic [1:0] BUF_NONE = 2'd3;

   // Lowest buffer that is neither held by the reader nor the latest published frame.
   function automatic logic [1:0] pick_buf(input logic [1:0] rd_buf,
                                           input logic [1:0] done_buf,
                                           input logic       done_valid);
      logic [1:0] excl;
      excl = done_valid ? done_buf : BUF_NONE;
      if (rd_buf != 2'd0 && excl != 2'd0)
         return 2'd0;
      else if (rd_buf != 2'd1 && excl != 2'd1)
         return 2'd1;
      else
         return 2'(NUM_BUF - 1);
   endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   output logic [15:0] cnt_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && cnt_q != 16'hFFFF)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= 16'd0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hram_frame_writer.sv
// Streams FIFO pixel words into one of three HyperRAM frame buffers and publishes
// the last completed buffer without ever writing into the one the reader holds.
//
// state   | meaning
// IDLE    | capture disabled, FIFO drained
// ARM     | enabled, draining until the first frame_start
// WRITE   | writing words of the current frame to wr_buf
// DISCARD | frame complete, popping surplus words until next frame_start
module hram_frame_writer
   import hram_fw_pkg::*;
#(
   parameter int FRAME_WORDS = 81920,
   parameter int OFFSET_W    = 17,
   parameter int ADDR_W      = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              frame_start,
   input  logic [15:0]       fifo_q,
   input  logic              fifo_empty,
   output logic              fifo_deq,
   output logic              sram_req,
   input  logic              sram_ready,
   output logic              sram_rd,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_wr_data,
   input  logic [1:0]        rd_buf,
   output logic [1:0]        done_buf,
   output logic              done_valid,
   output logic              frame_done,
   output logic [15:0]       overrun_cnt,
   output logic [15:0]       short_cnt
);

   localparam logic [OFFSET_W-1:0] LAST_OFS = OFFSET_W'(FRAME_WORDS - 1);

   state_t              state_q, state_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;
   logic [1:0]          wr_buf_q, wr_buf_d;
   logic [1:0]          done_buf_q, done_buf_d;
   logic                done_valid_q, done_valid_d;
   logic                frame_done_q, frame_done_d;
   logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
   logic                accept, last, short_inc, overrun_inc;

   always_comb begin
      sram_req = 1'b0;
      fifo_deq = 1'b0;
      unique case (state_q)
         IDLE:    fifo_deq = !fifo_empty;
         ARM:     fifo_deq = !fifo_empty && !frame_start;
         WRITE: begin
            sram_req = !fifo_empty;
            fifo_deq = !fifo_empty && sram_ready;
         end
         DISCARD: fifo_deq = !fifo_empty;
         default: fifo_deq = 1'b0;
      endcase
   end

   assign accept      = (state_q == WRITE) && sram_req && sram_ready;
   assign last        = accept && (offset_q == LAST_OFS);
   assign overrun_inc = (state_q == DISCARD) && !fifo_empty;

   always_comb begin
      state_d      = state_q;
      offset_d     = offset_q;
      wr_buf_d     = wr_buf_q;
      done_buf_d   = done_buf_q;
      done_valid_d = done_valid_q;
      frame_done_d = 1'b0;
      short_inc    = 1'b0;
      unique case (state_q)
         IDLE: if (enable) state_d = ARM;
         ARM, DISCARD: begin
            if (frame_start) begin
               state_d  = WRITE;
               wr_buf_d = pick_buf(rd_buf, done_buf_q, done_valid_q);
               offset_d = '0;
            end
         end
         WRITE: begin
            if (accept)
               offset_d = offset_q + OFFSET_W'(1);
            if (last) begin
               done_buf_d   = wr_buf_q;
               done_valid_d = 1'b1;
               frame_done_d = 1'b1;
               state_d      = DISCARD;
            end
            // Completion is folded in first so the reselect avoids the buffer just published.
            if (frame_start) begin
               short_inc = !last;
               state_d   = WRITE;
               wr_buf_d  = pick_buf(rd_buf, done_buf_d, done_valid_d);
               offset_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         state_d      = IDLE;
         done_buf_d   = done_buf_q;
         done_valid_d = done_valid_q;
         frame_done_d = 1'b0;
         short_inc    = 1'b0;
      end
   end

   assign sram_addr_d = ADDR_W'({wr_buf_d, offset_d});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         offset_q     <= '0;
         wr_buf_q     <= 2'd0;
         done_buf_q   <= 2'd0;
         done_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         sram_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         offset_q     <= offset_d;
         wr_buf_q     <= wr_buf_d;
         done_buf_q   <= done_buf_d;
         done_valid_q <= done_valid_d;
         frame_done_q <= frame_done_d;
         sram_addr_q  <= sram_addr_d;
      end
   end

   sat_cnt16 u_overrun_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (overrun_inc),
      .cnt_o (overrun_cnt)
   );

   sat_cnt16 u_short_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .inc_i (short_inc),
      .cnt_o (short_cnt)
   );

   assign sram_rd      = 1'b0;
   assign sram_wr_data = fifo_q;
   assign sram_addr    = sram_addr_q;
   assign done_buf     = done_buf_q;
   assign done_valid   = done_valid_q;
   assign frame_done   = frame_done_q;

endmodule
